// File: rtl/flag_register.sv
// flag_register: condition-code register for the execute stage.
// Holds the Z/N/C flags written by the ALU, decides JZ/JN/JC, applies
// SETC/CLRC, clears a flag when its jump is taken, and saves/restores the
// flags through a two-entry shadow stack on interrupt entry and RTI.
module flag_register (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_stall,
    input  logic       i_alu_we,
    input  logic       i_alu_zero,
    input  logic       i_alu_negative,
    input  logic       i_alu_carry,
    input  logic [1:0] i_flag_op,
    input  logic [1:0] i_jump_type,
    input  logic       i_int_save,
    input  logic       i_rti,
    output logic       o_zero_flag,
    output logic       o_negative_flag,
    output logic       o_carry_flag,
    output logic       o_jump_taken,
    output logic [1:0] o_depth,
    output logic       o_error
);

    // Shadow stack occupancy; the encoding doubles as the o_depth value.
    typedef enum logic [1:0] {
        DEPTH_EMPTY = 2'd0,
        DEPTH_ONE   = 2'd1,
        DEPTH_TWO   = 2'd2
    } depth_e;

    localparam logic [1:0] FLAG_OP_SETC = 2'b01;
    localparam logic [1:0] FLAG_OP_CLRC = 2'b10;
    localparam logic [1:0] JUMP_JZ      = 2'b01;
    localparam logic [1:0] JUMP_JN      = 2'b10;
    localparam logic [1:0] JUMP_JC      = 2'b11;

    // Architectural flags.
    logic       zero_q, zero_d;
    logic       negative_q, negative_d;
    logic       carry_q, carry_d;

    // Shadow stack: each entry packs {Z, N, C}.
    logic [2:0] stack_q [2];
    logic [2:0] stack_d [2];
    depth_e     depth_q, depth_d;
    logic       error_q, error_d;

    // Decoded control terms.
    logic       jz_taken;
    logic       jn_taken;
    logic       jc_taken;
    logic       pop_valid;
    logic       push_valid;
    logic       push_idx;
    logic       pop_idx;
    logic [2:0] pop_flags;
    logic       error_event;

    // Jump decision from the registered flags only, suppressed while stalled.
    always_comb begin
        jz_taken = 1'b0;
        jn_taken = 1'b0;
        jc_taken = 1'b0;
        if (!i_stall) begin
            jz_taken = (i_jump_type == JUMP_JZ) && zero_q;
            jn_taken = (i_jump_type == JUMP_JN) && negative_q;
            jc_taken = (i_jump_type == JUMP_JC) && carry_q;
        end
    end

    assign o_jump_taken = jz_taken | jn_taken | jc_taken;

    // Stack control: a pop wins over a simultaneous push, and any illegal
    // request (overflow, underflow, save+rti together) raises the error.
    always_comb begin
        pop_valid   = i_rti && (depth_q != DEPTH_EMPTY);
        push_valid  = i_int_save && !i_rti && (depth_q != DEPTH_TWO);
        push_idx    = (depth_q == DEPTH_ONE);
        pop_idx     = (depth_q == DEPTH_TWO);
        pop_flags   = stack_q[pop_idx];
        error_event = (i_int_save && i_rti)
                    || (i_int_save && (depth_q == DEPTH_TWO))
                    || (i_rti && (depth_q == DEPTH_EMPTY));
    end

    // Next-state flags: a valid pop overrides everything; otherwise each flag
    // independently takes its highest-priority source (ALU, SETC/CLRC, jump clear).
    always_comb begin
        zero_d     = zero_q;
        negative_d = negative_q;
        carry_d    = carry_q;
        if (!i_stall) begin
            if (pop_valid) begin
                zero_d     = pop_flags[2];
                negative_d = pop_flags[1];
                carry_d    = pop_flags[0];
            end else begin
                if (i_alu_we) begin
                    zero_d = i_alu_zero;
                end else if (jz_taken) begin
                    zero_d = 1'b0;
                end

                if (i_alu_we) begin
                    negative_d = i_alu_negative;
                end else if (jn_taken) begin
                    negative_d = 1'b0;
                end

                if (i_alu_we) begin
                    carry_d = i_alu_carry;
                end else if (i_flag_op == FLAG_OP_SETC) begin
                    carry_d = 1'b1;
                end else if (i_flag_op == FLAG_OP_CLRC) begin
                    carry_d = 1'b0;
                end else if (jc_taken) begin
                    carry_d = 1'b0;
                end
            end
        end
    end

    // Next-state stack, depth and sticky error; a push stores the registered flags.
    always_comb begin
        stack_d[0] = stack_q[0];
        stack_d[1] = stack_q[1];
        depth_d    = depth_q;
        error_d    = error_q;
        if (!i_stall) begin
            if (pop_valid) begin
                unique case (depth_q)
                    DEPTH_TWO: depth_d = DEPTH_ONE;
                    DEPTH_ONE: depth_d = DEPTH_EMPTY;
                    default:   depth_d = DEPTH_EMPTY;
                endcase
            end else if (push_valid) begin
                stack_d[push_idx] = {zero_q, negative_q, carry_q};
                unique case (depth_q)
                    DEPTH_EMPTY: depth_d = DEPTH_ONE;
                    DEPTH_ONE:   depth_d = DEPTH_TWO;
                    default:     depth_d = DEPTH_TWO;
                endcase
            end
            if (error_event) begin
                error_d = 1'b1;
            end
        end
    end

    // State registers; reset clears everything and overrides stall.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            zero_q     <= 1'b0;
            negative_q <= 1'b0;
            carry_q    <= 1'b0;
            stack_q[0] <= 3'b000;
            stack_q[1] <= 3'b000;
            depth_q    <= DEPTH_EMPTY;
            error_q    <= 1'b0;
        end else begin
            zero_q     <= zero_d;
            negative_q <= negative_d;
            carry_q    <= carry_d;
            stack_q[0] <= stack_d[0];
            stack_q[1] <= stack_d[1];
            depth_q    <= depth_d;
            error_q    <= error_d;
        end
    end

    assign o_zero_flag     = zero_q;
    assign o_negative_flag = negative_q;
    assign o_carry_flag    = carry_q;
    assign o_depth         = depth_q;
    assign o_error         = error_q;

endmodule

// File: tb/tb_flag_register.sv
// Directed testbench for flag_register: hand-computed expectations for the
// flags, jump decision, shadow stack depth and sticky error.
module tb_flag_register;

    logic       i_clk;
    logic       i_reset;
    logic       i_stall;
    logic       i_alu_we;
    logic       i_alu_zero;
    logic       i_alu_negative;
    logic       i_alu_carry;
    logic [1:0] i_flag_op;
    logic [1:0] i_jump_type;
    logic       i_int_save;
    logic       i_rti;
    logic       o_zero_flag;
    logic       o_negative_flag;
    logic       o_carry_flag;
    logic       o_jump_taken;
    logic [1:0] o_depth;
    logic       o_error;

    int checks;
    int errors;

    flag_register dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_stall        (i_stall),
        .i_alu_we       (i_alu_we),
        .i_alu_zero     (i_alu_zero),
        .i_alu_negative (i_alu_negative),
        .i_alu_carry    (i_alu_carry),
        .i_flag_op      (i_flag_op),
        .i_jump_type    (i_jump_type),
        .i_int_save     (i_int_save),
        .i_rti          (i_rti),
        .o_zero_flag    (o_zero_flag),
        .o_negative_flag(o_negative_flag),
        .o_carry_flag   (o_carry_flag),
        .o_jump_taken   (o_jump_taken),
        .o_depth        (o_depth),
        .o_error        (o_error)
    );

    // Free-running clock, period 10.
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive one cycle's worth of inputs; called just after a rising edge.
    task automatic applyStimulus(input logic rst, input logic stall,
                                 input logic aluWe, input logic [2:0] aluZnc,
                                 input logic [1:0] flagOp, input logic [1:0] jumpType,
                                 input logic intSave, input logic rti);
        i_reset        = rst;
        i_stall        = stall;
        i_alu_we       = aluWe;
        i_alu_zero     = aluZnc[2];
        i_alu_negative = aluZnc[1];
        i_alu_carry    = aluZnc[0];
        i_flag_op      = flagOp;
        i_jump_type    = jumpType;
        i_int_save     = intSave;
        i_rti          = rti;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic advanceClock();
        @(posedge i_clk);
        #1;
    endtask

    // Compare the registered outputs against hand-computed values.
    task automatic checkOutput(input string tag, input logic [2:0] expZnc,
                               input logic [1:0] expDepth, input logic expError);
        logic [2:0] obsZnc;
        obsZnc = {o_zero_flag, o_negative_flag, o_carry_flag};
        checks++;
        assert (obsZnc === expZnc) else begin
            errors++;
            $error("FAIL %s flags ZNC: observed %b expected %b", tag, obsZnc, expZnc);
        end
        checks++;
        assert (o_depth === expDepth) else begin
            errors++;
            $error("FAIL %s depth: observed %0d expected %0d", tag, o_depth, expDepth);
        end
        checks++;
        assert (o_error === expError) else begin
            errors++;
            $error("FAIL %s error: observed %b expected %b", tag, o_error, expError);
        end
    endtask

    // Compare the combinational jump decision for the inputs currently driven.
    task automatic checkJump(input string tag, input logic expJump);
        #1;
        checks++;
        assert (o_jump_taken === expJump) else begin
            errors++;
            $error("FAIL %s jump: observed %b expected %b", tag, o_jump_taken, expJump);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle();
        #1;

        // Reset, with stall also high: reset must win.
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0);
        advanceClock();
        idle();
        checkOutput("reset", 3'b000, 2'd0, 1'b0);
        checkJump("reset_nojump", 1'b0);

        // ALU update, then JZ taken and clearing Z.
        applyStimulus(1'b0, 1'b0, 1'b1, 3'b101, 2'b00, 2'b00, 1'b0, 1'b0);
        advanceClock();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 2'b01, 1'b0, 1'b0);
        checkOutput("alu_load", 3'b101, 2'd0, 1'b0);
        checkJump("jz_taken", 1'b1);
        advanceClock();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 2'b01, 1'b0, 1'b0);
        checkOutput("jz_clear", 3'b001, 2'd0, 1'b0);
        checkJump("jz_again", 1'b0);
        advanceClock();

        // ALU carry=0 beats SETC and the taken-JC clear.
        applyStimulus(1'b0, 1'b0, 1'b1, 3'b000, 2'b01, 2'b11, 1'b0, 1'b0);
        checkJump("jc_taken", 1'b1);
        advanceClock();
        idle();
        checkOutput("prio_alu", 3'b000, 2'd0, 1'b0);

        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 2'b01, 2'b00, 1'b0, 1'b0);
        advanceClock();
        idle();
        checkOutput("setc", 3'b001, 2'd0, 1'b0);

        // Stall holds everything and blocks the jump.
        applyStimulus(1'b0, 1'b1, 1'b1, 3'b110, 2'b10, 2'b11, 1'b1, 1'b0);
        checkJump("stall_nojump", 1'b0);
        advanceClock();
        idle();
        checkOutput("stall_hold", 3'b001, 2'd0, 1'b0);

        // SETC wins over a taken JC.
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 2'b01, 2'b11, 1'b0, 1'b0);
        checkJump("jc_setc", 1'b1);
        advanceClock();
        idle();
        checkOutput("setc_over_jc", 3'b001, 2'd0, 1'b0);

        // JN clear.
        applyStimulus(1'b0, 1'b0, 1'b1, 3'b010, 2'b00, 2'b00, 1'b0, 1'b0);
        advanceClock();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 2'b10, 1'b0, 1'b0);
        checkOutput("alu_n", 3'b010, 2'd0, 1'b0);
        checkJump("jn_taken", 1'b1);
        advanceClock();
        idle();
        checkOutput("jn_clear", 3'b000, 2'd0, 1'b0);

        // Nested interrupts.
        applyStimulus(1'b0, 1'b0, 1'b1, 3'b100, 2'b00, 2'b00, 1'b0, 1'b0);
        advanceClock();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00, 1'b1, 1'b0);
        advanceClock();
        idle();
        checkOutput("push1", 3'b100, 2'd1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 3'b011, 2'b00, 2'b00, 1'b0, 1'b0);
        advanceClock();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00, 1'b1, 1'b0);
        advanceClock();
        idle();
        checkOutput("push2", 3'b011, 2'd2, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0);
        advanceClock();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00, 1'b0, 1'b1);
        advanceClock();
        idle();
        checkOutput("pop1", 3'b011, 2'd1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00, 1'b0, 1'b1);
        advanceClock();
        idle();
        checkOutput("pop2", 3'b100, 2'd0, 1'b0);

        // Push saves the registered flags while the ALU updates the live ones.
        applyStimulus(1'b0, 1'b0, 1'b1, 3'b001, 2'b00, 2'b00, 1'b1, 1'b0);
        advanceClock();
        idle();
        checkOutput("push_with_alu", 3'b001, 2'd1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00, 1'b0, 1'b1);
        advanceClock();
        idle();
        checkOutput("pop_saved", 3'b100, 2'd0, 1'b0);

        // Overflow.
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00, 1'b1, 1'b0);
        advanceClock();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00, 1'b1, 1'b0);
        advanceClock();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00, 1'b1, 1'b0);
        advanceClock();
        idle();
        checkOutput("overflow", 3'b100, 2'd2, 1'b1);

        // Drain, then underflow: flags unchanged, then live update still applies.
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00, 1'b0, 1'b1);
        advanceClock();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00, 1'b0, 1'b1);
        advanceClock();
        idle();
        checkOutput("drain", 3'b100, 2'd0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00, 1'b0, 1'b1);
        advanceClock();
        idle();
        checkOutput("underflow", 3'b100, 2'd0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 3'b010, 2'b00, 2'b00, 1'b0, 1'b1);
        advanceClock();
        idle();
        checkOutput("underflow_alu", 3'b010, 2'd0, 1'b1);

        // Reset clears the sticky error; then save+rti conflict at depth 1.
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0);
        advanceClock();
        idle();
        checkOutput("reset2", 3'b000, 2'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 3'b111, 2'b00, 2'b00, 1'b0, 1'b0);
        advanceClock();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00, 1'b1, 1'b0);
        advanceClock();
        applyStimulus(1'b0, 1'b0, 1'b1, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0);
        advanceClock();
        idle();
        checkOutput("pre_conflict", 3'b000, 2'd1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 3'b001, 2'b01, 2'b00, 1'b1, 1'b1);
        advanceClock();
        idle();
        checkOutput("conflict", 3'b111, 2'd0, 1'b1);

        // Reset in the middle of a push.
        applyStimulus(1'b0, 1'b0, 1'b1, 3'b101, 2'b00, 2'b00, 1'b0, 1'b0);
        advanceClock();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00, 1'b1, 1'b0);
        advanceClock();
        idle();
        checkOutput("pre_reset_push", 3'b101, 2'd1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 3'b111, 2'b01, 2'b00, 1'b1, 1'b0);
        advanceClock();
        idle();
        checkOutput("reset_mid_push", 3'b000, 2'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/flag_register.md
# flag_register

Condition-code register for the execute stage: holds the architectural zero, negative and carry flags that the ALU produces and decides conditional jumps (JZ/JN/JC) on them. It applies SETC/CLRC and clears a tested flag when its jump is taken. It also saves flags on interrupt entry and restores them on RTI through a 2-entry shadow stack. It sits between the ALU flag outputs and the fetch/branch logic.

## Interface
- No parameters; widths are fixed.
- i_clk  input  1  clock; all state changes on the rising edge
- i_reset  input  1  synchronous, active-high reset
- i_stall  input  1  freeze all state; forces o_jump_taken low
- i_alu_we  input  1  ALU flag outputs are valid this cycle
- i_alu_zero / i_alu_negative / i_alu_carry  input  1 each  flags from the ALU
- i_flag_op  input  2  00 none, 01 SETC, 10 CLRC, 11 none
- i_jump_type  input  2  00 none, 01 JZ, 10 JN, 11 JC
- i_int_save  input  1  interrupt accepted: push the flags
- i_rti  input  1  return from interrupt: pop the flags
- o_zero_flag / o_negative_flag / o_carry_flag  output  1 each  registered flags Z/N/C
- o_jump_taken  output  1  combinational conditional-jump decision
- o_depth  output  2  shadow stack occupancy, 0..2
- o_error  output  1  sticky error flag (overflow, underflow or conflict)

## Operation
- **Jump decision:** o_jump_taken = !i_stall && (JZ&Z | JN&N | JC&C). It uses the registered flags only; there is no same-cycle bypass from the ALU.
- **Next-state flags when not stalled.** Priority is highest first.
  1. i_rti with depth>0: Z/N/C are loaded from the top stack entry and depth decrements. Every other flag source is ignored this cycle.
  2. i_alu_we: Z/N/C are loaded from the three ALU inputs.
  3. i_flag_op: SETC sets C, CLRC clears C. Z and N are unchanged.
  4. o_jump_taken: the tested flag is cleared (JZ→Z=0, JN→N=0, JC→C=0).
  - Within levels 2–4, the highest asserted source wins for each individual flag. Example: i_alu_we together with a taken JC loads the ALU carry, not 0.
- **Shadow stack:** two entries of {Z,N,C}, plus a depth state with three values: EMPTY (0), ONE (1), TWO (2).
  - i_int_save at depth<2: the current *registered* flags are pushed and depth increments. Same-cycle flag updates (levels 2–4) still apply to the live flags.
  - i_int_save at TWO: the push is dropped, depth stays 2 and o_error is set.
  - i_rti at EMPTY: the live flags update as if i_rti were low, depth stays 0 and o_error is set.
  - i_int_save and i_rti in the same cycle: the RTI pop is performed as in level 1, the push is dropped and o_error is set.
  - Popping takes the most recent push (LIFO).
- **Stall:** when i_stall=1, the flags, stack, depth and o_error all hold, and all other inputs are ignored.
- **Reset:** Z=N=C=0, depth=0, stack entries=0, o_error=0. Reset overrides stall and every other input. o_error is cleared only by reset.

## Timing
- All outputs except o_jump_taken are registered. Their reset values are 0.
- Flag update latency is 1 cycle: the ALU flags presented in cycle n appear on the outputs in cycle n+1 and are used for jump decisions from n+1 onward.
- o_jump_taken is combinational in the same cycle. The flag clear it causes is visible at n+1.
- Push/pop: o_depth changes 1 cycle after i_int_save or i_rti. A restored flag is visible 1 cycle after i_rti.
- Reset asserted in the middle of a push or pop: the stack and depth are cleared at that edge, with no partial update.

## Test plan
- **Reset, then ALU update:** i_alu_we with Z=1,N=0,C=1 → next cycle the outputs are Z=1,N=0,C=1, and o_jump_taken=1 when i_jump_type=01.
- **Jump clear:** Z=1 and i_jump_type=01 → o_jump_taken=1 in the same cycle; next cycle Z=0 while N and C are unchanged. Repeating JZ then gives o_jump_taken=0.
- **Priority:** Z/N/C=0/0/0 with i_alu_we carry=0, SETC and JC all in one cycle → C=0. Then SETC alone → C=1. Then i_stall=1 with CLRC → C stays 1 and o_jump_taken=0 for JC.
- **Nested interrupts:**
  - Flags 1/0/0, then i_int_save → depth=1.
  - Set flags to 0/1/1, then i_int_save → depth=2.
  - Clear all flags, then i_rti → flags 0/1/1, depth=1.
  - i_rti again → flags 1/0/0, depth=0. o_error stays 0 throughout.
- **Errors:** a third i_int_save at depth 2 → depth=2 and o_error=1. i_rti at depth 0 → flags unchanged and o_error=1. i_int_save together with i_rti at depth 1 → pop performed, depth=0, o_error=1.
- **Reset mid-operation:** i_reset and i_int_save asserted together at depth 1 → the next cycle shows depth=0, all flags 0 and o_error=0.
